// File: rtl/skipring_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// skipring_pkg : shared types, defaults and helpers for the skipring_mc block
// Revision     : 1.0
// ---------------------------------------------------------------------------
package skipring_pkg;

  localparam int DEF_LEN = 16;
  localparam int DEF_NCH = 4;
  localparam int DEF_CW  = 16;

  typedef enum logic [0:0] {
    LS_IDLE = 1'b0,
    LS_PEND = 1'b1
  } ld_state_e;

  // A requested length of 0 or beyond the physical ring selects the full ring.
  function automatic int clamp_len(input int ldlen, input int len);
    return ((ldlen == 0) || (ldlen > len)) ? len : ldlen;
  endfunction

  function automatic longint cnt_max(input int cw);
    return (longint'(1) << cw) - longint'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/skipring_mc_skip_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// skip_cnt : saturating skip counter, clear has priority over increment
// Revision : 1.0
// ---------------------------------------------------------------------------
module skip_cnt
  import skipring_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o
);

  localparam logic [CW-1:0] CNT_MAX = CW'(cnt_max(CW));

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/skipring_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// skipring_mc : multi-channel programmable-length clock-enable skip ring
// Revision    : 1.0
// ---------------------------------------------------------------------------
module skipring_mc
  import skipring_pkg::*;
#(
  parameter int             LEN    = DEF_LEN,
  parameter int             NCH    = DEF_NCH,
  parameter int             CW     = DEF_CW,
  parameter logic [LEN-1:0] defSEL = LEN'(1),
  parameter int             LW     = $clog2(LEN + 1)
) (
  input  logic                iCLK,
  input  logic                RST,
  input  logic                E,
  input  logic                LD,
  input  logic                LDNOW,
  input  logic [LEN-1:0]      LDSEL,
  input  logic [LW-1:0]       LDLEN,
  input  logic [NCH*LEN-1:0]  MASK,
  input  logic                CLR,
  output logic [NCH-1:0]      oCE,
  output logic [LW-1:0]       oPOS,
  output logic                oWRAP,
  output logic                oBUSY,
  output logic                oST,
  output logic [NCH*CW-1:0]   oSKCNT
);

  logic            e_q;
  logic [LEN-1:0]  sel_q, sel_d, sel_rot, ssel_q;
  logic [LW-1:0]   len_q, len_d, pos_q, pos_d, slen_q;
  ld_state_e       state_q;
  logic            busy_q;

  logic            w_wrap, w_idle, w_imm, w_cap, w_def, w_last;
  logic [LW-1:0]   w_ldlen;
  logic [NCH-1:0]  w_hit;

  function automatic logic [LEN-1:0] len_mask(input logic [LW-1:0] l);
    logic [LEN-1:0] m;
    m = '0;
    for (int i = 0; i < LEN; i++) begin
      if (i < int'(l)) m[i] = 1'b1;
    end
    return m;
  endfunction

  assign w_ldlen = LW'(clamp_len(int'(LDLEN), LEN));
  assign w_wrap  = e_q && (pos_q == (len_q - LW'(1)));
  assign w_idle  = (state_q == LS_IDLE);
  assign w_imm   = LD && LDNOW && w_idle;
  assign w_cap   = LD && !LDNOW && w_idle;
  assign w_def   = !w_idle && w_wrap;

  // Rotate only the active L bits; the top slot feeds slot 0.
  always_comb begin
    w_last  = 1'b0;
    sel_rot = '0;
    for (int j = 0; j < LEN; j++) begin
      if (j == int'(len_q) - 1) w_last = sel_q[j];
    end
    sel_rot[0] = w_last;
    for (int i = 1; i < LEN; i++) begin
      if (i < int'(len_q)) sel_rot[i] = sel_q[i-1];
    end
  end

  always_comb begin
    sel_d = sel_q;
    len_d = len_q;
    pos_d = pos_q;
    if (w_imm) begin
      sel_d = LDSEL & len_mask(w_ldlen);
      len_d = w_ldlen;
      pos_d = '0;
    end else if (w_def) begin
      sel_d = ssel_q;
      len_d = slen_q;
      pos_d = '0;
    end else if (e_q) begin
      sel_d = sel_rot;
      pos_d = (pos_q == (len_q - LW'(1))) ? '0 : pos_q + LW'(1);
    end
  end

  always_ff @(posedge iCLK) begin
    if (!RST) begin
      e_q   <= 1'b0;
      sel_q <= defSEL;
      len_q <= LW'(LEN);
      pos_q <= '0;
    end else begin
      e_q   <= E;
      sel_q <= sel_d;
      len_q <= len_d;
      pos_q <= pos_d;
    end
  end

  // Deferred-load FSM; the shadow is stored already clamped and masked.
  always_ff @(posedge iCLK) begin
    if (!RST) begin
      state_q <= LS_IDLE;
      busy_q  <= 1'b0;
      ssel_q  <= '0;
      slen_q  <= '0;
    end else begin
      case (state_q)
        LS_IDLE: begin
          if (w_cap) begin
            state_q <= LS_PEND;
            busy_q  <= 1'b1;
            ssel_q  <= LDSEL & len_mask(w_ldlen);
            slen_q  <= w_ldlen;
          end
        end
        LS_PEND: begin
          if (w_wrap) begin
            state_q <= LS_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= LS_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign w_hit[c] = e_q && (|(sel_q & MASK[c*LEN +: LEN]));
    assign oCE[c]   = ~w_hit[c];

    skip_cnt #(.CW(CW)) u_cnt (
      .clk_i   (iCLK),
      .rst_n_i (RST),
      .inc_i   (w_hit[c]),
      .clr_i   (CLR),
      .cnt_o   (oSKCNT[c*CW +: CW])
    );
  end

  assign oPOS  = pos_q;
  assign oWRAP = w_wrap;
  assign oBUSY = busy_q;
  assign oST   = e_q;

endmodule
`default_nettype wire

// File: tb/tb_skipring_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_skipring_mc : scoreboard bench for skipring_mc (LEN=16, NCH=4, CW=4)
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_skipring_mc;

  localparam int LEN = 16;
  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int LW  = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic               clk = 1'b0;
  logic               rst, e, ld, ldnow, clr;
  logic [LEN-1:0]     ldsel;
  logic [LW-1:0]      ldlen;
  logic [NCH*LEN-1:0] mask;
  logic [NCH-1:0]     o_ce;
  logic [LW-1:0]      o_pos;
  logic               o_wrap, o_busy, o_st;
  logic [NCH*CW-1:0]  o_skcnt;

  skipring_mc #(.LEN(LEN), .NCH(NCH), .CW(CW), .defSEL(16'h0001)) dut (
    .iCLK(clk), .RST(rst), .E(e), .LD(ld), .LDNOW(ldnow), .LDSEL(ldsel),
    .LDLEN(ldlen), .MASK(mask), .CLR(clr), .oCE(o_ce), .oPOS(o_pos),
    .oWRAP(o_wrap), .oBUSY(o_busy), .oST(o_st), .oSKCNT(o_skcnt)
  );

  always #5 clk = ~clk;

  logic [63:0] dut_v;
  assign dut_v = {36'b0, o_skcnt, o_st, o_busy, o_wrap, o_pos, o_ce};

  int n_tests = 0;
  int n_fail  = 0;
  string ph = "init";
  logic [63:0] exp_q[$];

  // Reference model state
  logic        m_e = 1'b0, m_busy = 1'b0;
  logic [15:0] m_sel = 16'h0001, m_ssel = '0;
  int          m_len = 16, m_pos = 0, m_slen = 0;
  int          m_cnt[NCH] = '{default: 0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  function automatic logic [15:0] lmask(input int l);
    logic [31:0] t;
    t = (32'h1 << l) - 32'h1;
    return t[15:0];
  endfunction

  function automatic int mclamp(input int l);
    return (l == 0 || l > LEN) ? LEN : l;
  endfunction

  function automatic logic m_hit(input int c);
    logic [15:0] mk;
    mk = mask[c*LEN +: LEN];
    return m_e && ((m_sel & mk) != 16'h0);
  endfunction

  function automatic logic [63:0] model_out();
    logic [3:0]  ce;
    logic [15:0] cnt;
    logic        wr;
    for (int c = 0; c < NCH; c++) begin
      ce[c] = !m_hit(c);
      cnt[c*CW +: CW] = 4'(m_cnt[c]);
    end
    wr = m_e && (m_pos == m_len - 1);
    return {36'b0, cnt, m_e, m_busy, wr, 5'(m_pos), ce};
  endfunction

  task automatic model_step();
    logic wr, imm, cap, dfr;
    int   nl;
    if (!rst) begin
      m_e = 1'b0; m_busy = 1'b0; m_sel = 16'h0001; m_ssel = '0;
      m_len = 16; m_pos = 0; m_slen = 0;
      for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
      return;
    end
    wr  = m_e && (m_pos == m_len - 1);
    imm = ld && ldnow && !m_busy;
    cap = ld && !ldnow && !m_busy;
    dfr = m_busy && wr;
    nl  = mclamp(int'(ldlen));
    for (int c = 0; c < NCH; c++) begin
      if (clr) m_cnt[c] = 0;
      else if (m_hit(c) && m_cnt[c] < CMAX) m_cnt[c]++;
    end
    if (imm) begin
      m_sel = ldsel & lmask(nl); m_len = nl; m_pos = 0;
    end else if (dfr) begin
      m_sel = m_ssel; m_len = m_slen; m_pos = 0; m_busy = 1'b0;
    end else if (m_e) begin
      m_sel = ((m_sel << 1) | (m_sel >> (m_len - 1))) & lmask(m_len);
      m_pos = (m_pos == m_len - 1) ? 0 : m_pos + 1;
    end
    if (cap) begin
      m_ssel = ldsel & lmask(nl); m_slen = nl; m_busy = 1'b1;
    end
    m_e = e;
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      model_step();
      exp_q.push_back(model_out());
      @(posedge clk);
      #1;
      chk(ph, dut_v, exp_q.pop_front());
    end
  endtask

  initial begin
    rst = 1'b0; e = 1'b1; ld = 1'b0; ldnow = 1'b0; clr = 1'b0;
    ldsel = '0; ldlen = '0; mask = 64'h0000_0000_0000_0001;

    ph = "reset";
    cyc(2);
    chk("rst_ce", {60'b0, o_ce}, 64'hF);
    chk("rst_st", {63'b0, o_st}, 64'h0);
    rst = 1'b1;
    ph = "ring16";
    cyc(36);

    ph = "imm_load";
    mask = 64'h0000_0000_0001_0001;
    ld = 1'b1; ldnow = 1'b1; ldsel = 16'h0005; ldlen = 5'd4;
    cyc(1);
    ld = 1'b0;
    chk("imm_pos", {59'b0, o_pos}, 64'h0);
    cyc(9);

    ph = "def_load";
    for (int g = 0; g < 20 && m_pos != 1; g++) cyc(1);
    chk("pos1", {59'b0, o_pos}, 64'h1);
    ld = 1'b1; ldnow = 1'b0; ldsel = 16'h0003; ldlen = 5'd8;
    cyc(1);
    chk("busy_set", {63'b0, o_busy}, 64'h1);
    ldnow = 1'b1; ldsel = 16'hFFFF; ldlen = 5'd2;
    cyc(1);
    ld = 1'b0;
    cyc(12);

    ph = "pause";
    mask = 64'hF0F0_0000_00FF_0101;
    e = 1'b0;
    cyc(6);
    chk("pause_ce", {60'b0, o_ce}, 64'hF);
    e = 1'b1;
    cyc(6);

    ph = "sat";
    mask = 64'h0000_FFFF_0000_0001;
    ld = 1'b1; ldnow = 1'b1; ldsel = 16'h0001; ldlen = 5'd16;
    cyc(1);
    ld = 1'b0;
    cyc(20);
    chk("sat15", {60'b0, o_skcnt[2*CW +: CW]}, 64'hF);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr0", {60'b0, o_skcnt[2*CW +: CW]}, 64'h0);
    cyc(3);

    ph = "clamp";
    ld = 1'b1; ldnow = 1'b1; ldsel = 16'h8001; ldlen = 5'd0;
    cyc(1);
    ld = 1'b0;
    cyc(18);
    ld = 1'b1; ldsel = 16'h8003; ldlen = 5'd20;
    cyc(1);
    ld = 1'b0;
    cyc(18);

    ph = "rst_busy";
    ld = 1'b1; ldnow = 1'b0; ldsel = 16'h0007; ldlen = 5'd3;
    cyc(1);
    ld = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("rst_busy0", {63'b0, o_busy}, 64'h0);
    rst = 1'b1;
    cyc(40);

    ph = "random";
    for (int r = 0; r < 200; r++) begin
      e     = ($urandom_range(0, 7) != 0);
      ld    = ($urandom_range(0, 5) == 0);
      ldnow = 1'($urandom);
      ldsel = 16'($urandom);
      ldlen = 5'($urandom_range(0, 20));
      clr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) mask = {$urandom, $urandom};
      cyc(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
